// File: rtl/pulse_scheduler.sv
// pulse_scheduler: sequences trigger pulses for the timing front end.
// On a start edge the latched 4-bit channel mask is walked from the lowest to the highest set
// bit. Each selected channel drives the shared trigger high for its duration, followed by a
// fixed idle gap. All timing is counted in divider ticks. In auto mode the pass repeats.
//
// Ports:
//   sysclk - system clock
//   rst    - synchronous active-high reset
//   tick   - one-cycle timebase strobe from the clock divider
//   start  - start/abort level, rising edge detected internally
//   auto   - when high at the end of a pass, the pass repeats
//   sel    - channel mask, latched on an accepted start
//   busy   - high from the accepted start until the return to idle
//   out    - trigger pulse active
//   chan   - index of the current or last channel
//   ch_en  - one-hot copy of out per channel
//   done   - one-cycle strobe at the end of each completed pass
module pulse_scheduler #(
   parameter int unsigned DUR0 = 131,
   parameter int unsigned DUR1 = 120,
   parameter int unsigned DUR2 = 87,
   parameter int unsigned DUR3 = 54,
   parameter int unsigned GAP  = 16,
   parameter int unsigned CW   = 9
) (
   input  logic       sysclk,
   input  logic       rst,
   input  logic       tick,
   input  logic       start,
   input  logic       auto,
   input  logic [3:0] sel,
   output logic       busy,
   output logic       out,
   output logic [1:0] chan,
   output logic [3:0] ch_en,
   output logic       done
);

   if (DUR0 == 0 || DUR1 == 0 || DUR2 == 0 || DUR3 == 0) begin : g_dur_zero
      $error("pulse_scheduler: every DURx must be >= 1");
   end
   if (DUR0 > (2 ** CW) - 1 || DUR1 > (2 ** CW) - 1 || DUR2 > (2 ** CW) - 1 ||
       DUR3 > (2 ** CW) - 1 || GAP > (2 ** CW) - 1) begin : g_dur_wide
      $error("pulse_scheduler: durations and gap must fit in CW bits");
   end

   typedef enum logic [2:0] {StIdle, StScan, StPulse, StGap, StDone} state_e;

   // Only meaningful when GAP > 0; the GAP state is never entered otherwise.
   localparam logic [CW-1:0] GapLast = CW'(GAP - 1);

   state_e        state_q;
   logic          start_q;
   logic [3:0]    sel_lat_q;
   logic [3:0]    rem_q;
   logic [CW-1:0] cnt_q;
   logic          busy_q;
   logic          out_q;
   logic [1:0]    chan_q;
   logic [3:0]    ch_en_q;
   logic          done_q;

   logic          start_edge;
   logic [1:0]    low_idx;
   logic [CW-1:0] dur_last;

   assign start_edge = start & ~start_q;

   always_comb begin
      low_idx = 2'd3;
      if (rem_q[0]) begin
         low_idx = 2'd0;
      end else if (rem_q[1]) begin
         low_idx = 2'd1;
      end else if (rem_q[2]) begin
         low_idx = 2'd2;
      end
   end

   always_comb begin
      dur_last = CW'(DUR0 - 1);
      case (chan_q)
         2'd0:    dur_last = CW'(DUR0 - 1);
         2'd1:    dur_last = CW'(DUR1 - 1);
         2'd2:    dur_last = CW'(DUR2 - 1);
         default: dur_last = CW'(DUR3 - 1);
      endcase
   end

   always_ff @(posedge sysclk) begin
      if (rst) begin
         state_q   <= StIdle;
         start_q   <= 1'b0;
         sel_lat_q <= 4'd0;
         rem_q     <= 4'd0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         out_q     <= 1'b0;
         chan_q    <= 2'd0;
         ch_en_q   <= 4'd0;
         done_q    <= 1'b0;
      end else begin
         start_q <= start;
         done_q  <= 1'b0;
         if (start_edge && state_q != StIdle) begin
            // Abort: chan keeps its last value, done is suppressed.
            state_q <= StIdle;
            busy_q  <= 1'b0;
            out_q   <= 1'b0;
            ch_en_q <= 4'd0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start_edge && sel != 4'd0) begin
                     sel_lat_q <= sel;
                     rem_q     <= sel;
                     busy_q    <= 1'b1;
                     state_q   <= StScan;
                  end
               end
               StScan: begin
                  if (rem_q != 4'd0) begin
                     chan_q  <= low_idx;
                     rem_q   <= rem_q & (rem_q - 4'd1);  // drop lowest set bit
                     cnt_q   <= '0;
                     out_q   <= 1'b1;
                     ch_en_q <= 4'b0001 << low_idx;
                     state_q <= StPulse;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
               StPulse: begin
                  if (tick) begin
                     if (cnt_q == dur_last) begin
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                        ch_en_q <= 4'd0;
                        state_q <= (GAP == 0) ? StScan : StGap;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               StGap: begin
                  if (tick) begin
                     if (cnt_q == GapLast) begin
                        cnt_q   <= '0;
                        state_q <= StScan;
                     end else begin
                        cnt_q <= cnt_q + 1'b1;
                     end
                  end
               end
               StDone: begin
                  if (auto) begin
                     rem_q   <= sel_lat_q;  // repeat uses the latched mask, not live sel
                     state_q <= StScan;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign busy  = busy_q;
   assign out   = out_q;
   assign chan  = chan_q;
   assign ch_en = ch_en_q;
   assign done  = done_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Bench for pulse_scheduler: two instances (default parameters, and a short-duration GAP=0
// variant) are driven from shared stimulus and compared every cycle against a schedule-based
// reference model.
module tb_pulse_scheduler;

   logic       sysclk = 1'b0;
   logic       rst, tick, start, auto;
   logic [3:0] sel;

   logic       busy0, out0, done0;
   logic [1:0] chan0;
   logic [3:0] ch_en0;
   logic       busy1, out1, done1;
   logic [1:0] chan1;
   logic [3:0] ch_en1;

   always #5 sysclk = ~sysclk;

   pulse_scheduler u_dut0 (
      .sysclk (sysclk),
      .rst    (rst),
      .tick   (tick),
      .start  (start),
      .auto   (auto),
      .sel    (sel),
      .busy   (busy0),
      .out    (out0),
      .chan   (chan0),
      .ch_en  (ch_en0),
      .done   (done0)
   );

   pulse_scheduler #(
      .DUR0 (5),
      .DUR1 (3),
      .DUR2 (2),
      .DUR3 (1),
      .GAP  (0),
      .CW   (4)
   ) u_dut1 (
      .sysclk (sysclk),
      .rst    (rst),
      .tick   (tick),
      .start  (start),
      .auto   (auto),
      .sel    (sel),
      .busy   (busy1),
      .out    (out1),
      .chan   (chan1),
      .ch_en  (ch_en1),
      .done   (done1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   // Reference model: a pass is a list of segments (scan cycle, pulse, gap, done cycle).
   localparam int KIdle  = 0;
   localparam int KScan  = 1;
   localparam int KPulse = 2;
   localparam int KGap   = 3;
   localparam int KDone  = 4;

   int         dur   [2][4];
   int         gapv  [2];
   int         kind  [2];
   int         left  [2];
   int         segk  [2][16];
   int         segc  [2][16];
   int         segn  [2];
   int         segp  [2];
   logic       m_busy[2];
   logic       m_out [2];
   logic       m_done[2];
   logic [1:0] m_chan[2];
   logic [3:0] m_chen[2];
   logic [3:0] m_mask[2];
   logic       start_prev;

   task automatic push_seg(input int i, input int k, input int c);
      segk[i][segn[i]] = k;
      segc[i][segn[i]] = c;
      segn[i]++;
   endtask

   task automatic build_pass(input int i, input logic [3:0] mask);
      segn[i] = 0;
      segp[i] = 0;
      for (int c = 0; c < 4; c++) begin
         if (mask[c]) begin
            push_seg(i, KScan, 0);
            push_seg(i, KPulse, c);
            if (gapv[i] > 0) push_seg(i, KGap, 0);
         end
      end
      push_seg(i, KScan, 0);
      push_seg(i, KDone, 0);
   endtask

   task automatic advance(input int i);
      int k;
      int c;
      k = segk[i][segp[i]];
      c = segc[i][segp[i]];
      segp[i]++;
      kind[i] = k;
      case (k)
         KPulse: begin
            m_out[i]  = 1'b1;
            m_chan[i] = 2'(c);
            m_chen[i] = 4'(1 << c);
            left[i]   = dur[i][c];
         end
         KGap:  left[i]   = gapv[i];
         KDone: m_done[i] = 1'b1;
         default: ;
      endcase
   endtask

   task automatic model_step(input int i, input logic sedge);
      if (rst) begin
         kind[i]   = KIdle;
         m_busy[i] = 1'b0;
         m_out[i]  = 1'b0;
         m_done[i] = 1'b0;
         m_chan[i] = 2'd0;
         m_chen[i] = 4'd0;
         m_mask[i] = 4'd0;
         return;
      end
      m_done[i] = 1'b0;
      if (kind[i] != KIdle && sedge) begin
         kind[i]   = KIdle;
         m_busy[i] = 1'b0;
         m_out[i]  = 1'b0;
         m_chen[i] = 4'd0;
      end else begin
         case (kind[i])
            KIdle: begin
               if (sedge && sel != 4'd0) begin
                  m_mask[i] = sel;
                  m_busy[i] = 1'b1;
                  build_pass(i, sel);
                  advance(i);
               end
            end
            KScan: advance(i);
            KPulse, KGap: begin
               if (tick) begin
                  left[i]--;
                  if (left[i] == 0) begin
                     m_out[i]  = 1'b0;
                     m_chen[i] = 4'd0;
                     advance(i);
                  end
               end
            end
            default: begin  // KDone
               if (auto) begin
                  build_pass(i, m_mask[i]);
                  advance(i);
               end else begin
                  m_busy[i] = 1'b0;
                  kind[i]   = KIdle;
               end
            end
         endcase
      end
   endtask

   task automatic cycle();
      logic sedge;
      @(posedge sysclk);
      sedge = start && !start_prev;
      model_step(0, sedge);
      model_step(1, sedge);
      start_prev = rst ? 1'b0 : start;
      #1;
      check_eq("busy0",  32'(busy0),  32'(m_busy[0]));
      check_eq("out0",   32'(out0),   32'(m_out[0]));
      check_eq("chan0",  32'(chan0),  32'(m_chan[0]));
      check_eq("ch_en0", 32'(ch_en0), 32'(m_chen[0]));
      check_eq("done0",  32'(done0),  32'(m_done[0]));
      check_eq("busy1",  32'(busy1),  32'(m_busy[1]));
      check_eq("out1",   32'(out1),   32'(m_out[1]));
      check_eq("chan1",  32'(chan1),  32'(m_chan[1]));
      check_eq("ch_en1", 32'(ch_en1), 32'(m_chen[1]));
      check_eq("done1",  32'(done1),  32'(m_done[1]));
   endtask

   // tick_period 0 selects random ticks (about one in three cycles).
   int tick_period = 4;
   int tick_phase  = 0;

   task automatic run(input int n);
      for (int k = 0; k < n; k++) begin
         if (tick_period == 0) begin
            tick = ($urandom_range(0, 2) == 0);
         end else begin
            tick = (tick_phase % tick_period == 0);
         end
         tick_phase++;
         cycle();
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      run(2);
      start = 1'b0;
   endtask

   initial begin
      dur[0][0] = 131; dur[0][1] = 120; dur[0][2] = 87; dur[0][3] = 54; gapv[0] = 16;
      dur[1][0] = 5;   dur[1][1] = 3;   dur[1][2] = 2;  dur[1][3] = 1;  gapv[1] = 0;
      for (int i = 0; i < 2; i++) begin
         kind[i] = KIdle; segn[i] = 0; segp[i] = 0; left[i] = 0;
      end
      start_prev = 1'b0;
      rst = 1'b1; tick = 1'b0; start = 1'b0; auto = 1'b0; sel = 4'd0;
      run(3);
      rst = 1'b0;
      run(5);

      // Single channel.
      sel = 4'b0001;
      pulse_start();
      run(660);

      // Multi-channel order.
      sel = 4'b1010;
      pulse_start();
      run(900);

      // Auto repeat; live sel change is ignored; dropping auto finishes the pass.
      auto = 1'b1;
      sel  = 4'b0100;
      pulse_start();
      run(850);
      sel = 4'b0001;
      run(400);
      auto = 1'b0;
      run(500);

      // Abort mid-pulse, then a start with an empty mask.
      sel = 4'b0010;
      pulse_start();
      run(160);
      pulse_start();
      run(20);
      sel = 4'b0000;
      pulse_start();
      run(20);

      // Reset while pulsing.
      sel = 4'b0001;
      pulse_start();
      run(100);
      rst = 1'b1;
      run(3);
      rst = 1'b0;
      run(5);

      // Tick every cycle so ticks coincide with scan cycles.
      tick_period = 1;
      sel = 4'b1001;
      pulse_start();
      run(700);

      // Random mix of ticks, starts/aborts, auto and masks.
      tick_period = 0;
      for (int k = 0; k < 6000; k++) begin
         if ($urandom_range(0, 99) == 0) start = ~start;
         if ($urandom_range(0, 299) == 0) auto = ~auto;
         sel = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 1999) == 0);
         run(1);
      end
      rst = 1'b0;
      run(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pulse_scheduler.md
Name: pulse_scheduler

Overview:
Sequences the switch-selected trigger pulses for the timing front end. On a start request it walks the latched 4-bit channel mask from lowest to highest set bit. For each channel it drives the shared trigger output high for that channel's duration, then inserts a fixed idle gap. Durations and gaps are counted in divider ticks. Optional auto mode repeats the whole sequence until auto is dropped or the run is aborted.

Parameters:
DUR0, 131, duration of channel 0 pulse in ticks (1..2^CW-1)
DUR1, 120, duration of channel 1 pulse in ticks
DUR2, 87, duration of channel 2 pulse in ticks
DUR3, 54, duration of channel 3 pulse in ticks
GAP, 16, idle ticks between pulses and between auto repeats (0..2^CW-1; 0 = no gap)
CW, 9, tick counter width

Ports:
sysclk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-sysclk-wide strobe from the clock divider; the timebase unit
start  in  1  debounced start/abort level; rising edge detected internally
auto  in  1  level; when 1 the sequence repeats
sel  in  4  channel mask, sampled at start
busy  out  1  high from the accepted start until return to IDLE
out  out  1  trigger pulse active (registered)
chan  out  2  index of the current or last channel
ch_en  out  4  one-hot copy of out per channel
done  out  1  one-sysclk strobe at the end of each completed sequence pass

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a sysclk edge), regardless of state:
  - state=IDLE;
  - busy, out, done, chan, ch_en, counters, mask registers and start edge register all 0.
- Start edge: start_q is the previous-cycle start; an edge is start=1 and start_q=0.
- States: IDLE, SCAN, PULSE, GAP, DONE.
- IDLE:
  - Edge with sel!=0: sel_lat<=sel, rem<=sel, busy<=1, go to SCAN.
  - Edge with sel==0: ignored, stays in IDLE.
- SCAN (1 cycle):
  - rem!=0: chan<=index of the lowest set bit in rem; clear that bit; cnt<=0; go to PULSE.
  - rem==0: go to DONE.
  - A tick in the SCAN cycle is not counted.
- PULSE:
  - out=1, ch_en[chan]=1 for every cycle spent in PULSE.
  - On each tick: cnt<=cnt+1.
  - On a tick with cnt==DURchan-1: go to GAP (or SCAN if GAP==0), cnt<=0.
  - The pulse therefore spans exactly DURchan ticks after entry. out falls in the cycle after the final tick.
- GAP:
  - out=0.
  - Counts ticks the same way; on a tick with cnt==GAP-1, go to SCAN.
- DONE (1 cycle): done=1.
  - auto=1: rem<=sel_lat (the latched mask, not live sel), go to SCAN. There is no extra gap beyond the one after the last pulse.
  - auto=0: busy<=0, go to IDLE.
- Abort: a start edge in any state other than IDLE:
  - next cycle state=IDLE, out=0, ch_en=0, busy=0;
  - done is not asserted; chan holds its value.
- sel changes while busy are ignored.
- auto is examined only in DONE. Dropping auto mid-pass lets the current pass finish.
- tick simultaneous with abort: abort wins.
- No wrap-around: cnt never exceeds max(DURx, GAP)-1.
- Elaboration check: every DURx must be >=1.

Test Plan:
1. Reset: rst high 3 cycles mid-PULSE (out=1) -> next cycle out=0, ch_en=0, busy=0, done=0, chan=0, state IDLE.
2. Single channel: sel=0001, tick every 4 sysclk, start edge -> out/ch_en=0001 high for exactly 131 ticks (524 sysclk ±1 tick alignment), 16-tick gap, done one cycle, busy falls the same cycle as done+1.
3. Multi-channel order: sel=1010 -> chan=1 pulse 120 ticks, 16-tick gap, chan=3 pulse 54 ticks, 16-tick gap, done; ch_en=0010 then 1000, never both.
4. Auto repeat: auto=1, sel=0100 -> repeated 87-tick pulses separated by 16 ticks, done each pass. Change sel to 0001 mid-run -> still channel 2. Drop auto -> current pass completes, then IDLE.
5. Abort and ignore: start edge at tick 40 of a DUR1 pulse -> out=0 next cycle, busy=0, no done. Start edge with sel=0000 -> busy stays 0.
6. Edge cases with GAP=0, DUR3=1: sel=1001 -> channel 0 pulse, SCAN, then channel 3 pulse of exactly 1 tick, no idle between. A tick coincident with the SCAN cycle is not counted.
